backscatter_scheduler: RTL and testbench

- Sequences the backscatter modulator (20 MHz, 50 ns/count) across a multi-packet payload: one payload bit per received excitation packet.
- Sees the decoded packet envelope DEC_IN and drives the modulator's EN (MOD_EN).
  - Bit 1: enables the modulator, which then produces its 4 us low window.
  - Bit 0: holds the modulator disabled, so no window is produced.
- Applies synchronization-error compensation by delaying MOD_EN by a selectable number of cycles after the packet edge. Sits between the envelope decoder and the modulator.

---
 rtl/backscatter_pkg.sv | 43 ++++
 rtl/pkt_edge_timer.sv | 38 +++
 rtl/backscatter_scheduler.sv | 136 +++++++++++++
 tb/tb_backscatter_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/backscatter_pkg.sv
// Shared types and constants for the backscatter modulator scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package backscatter_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_ACTIVE
  } sched_state_t;

  // One core clock tick at 20 MHz
  localparam int TICK_NS      = 50;
  // Highest meaningful SYNC_SEL step; larger codes clamp here
  localparam int SYNC_SEL_MAX = 8;
  // SYNC_SEL code that applies the base delay with no offset
  localparam int SYNC_CENTRE  = 4;
  // Packet length counter width (saturating)
  localparam int LEN_W        = 16;
  // Delay counter width, wide enough for any sane base/step combination
  localparam int DLY_W        = 8;

  // Clamp a raw sync step code to 0..SYNC_SEL_MAX
  function automatic logic [3:0] clamp_sel(input logic [3:0] sel);
    logic [3:0] lim;
    lim = 4'(SYNC_SEL_MAX);
    return (sel > lim) ? lim : sel;
  endfunction

  // Cycles between the packet rise and MOD_EN for a given step code.
  // Negative results (only possible with odd parameters) floor at zero.
  function automatic logic [DLY_W-1:0] sync_delay(input logic [3:0] sel,
                                                  input int base,
                                                  input int step);
    int d;
    d = base + (int'(clamp_sel(sel)) - SYNC_CENTRE) * step;
    if (d < 0) d = 0;
    return DLY_W'(d);
  endfunction

endpackage

// File: rtl/pkt_edge_timer.sv
// Registers the packet envelope, flags its rise/fall and measures packet length.
// Latency: rise/fall combinational on the edge cycle; pkt_len holds the length on the fall cycle.
// Backpressure: none; the envelope is sampled every cycle.
module pkt_edge_timer
  import backscatter_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             DEC_IN,
  output logic             rise,
  output logic             fall,
  output logic [LEN_W-1:0] pkt_len
);

  logic             dec_q;
  logic [LEN_W-1:0] len_q;

  assign rise    = DEC_IN & ~dec_q;
  assign fall    = ~DEC_IN & dec_q;
  // On the fall cycle len_q equals the number of high cycles including the rise cycle
  assign pkt_len = len_q;

  // Envelope history and saturating length count (rise cycle counts as 1)
  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_q <= 1'b0;
      len_q <= '0;
    end else begin
      dec_q <= DEC_IN;
      if (DEC_IN && !dec_q) begin
        len_q <= LEN_W'(1);
      end else if (DEC_IN && (len_q != '1)) begin
        len_q <= len_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/backscatter_scheduler.sv
// Schedules one payload bit per excitation packet onto the modulator enable, with sync delay.
// Latency: MOD_EN rises delay+1 cycles after the rise cycle, drops one cycle after the fall.
// Backpressure: none; packets and LOAD are taken as they come, runts are retried.
module backscatter_scheduler
  import backscatter_pkg::*;
#(
  parameter int PAYLOAD_BITS = 16,
  parameter int SYNC_BASE    = 12,
  parameter int SYNC_STEP    = 3,
  parameter int MIN_PKT      = 820
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          DEC_IN,
  input  logic                          LOAD,
  input  logic [PAYLOAD_BITS-1:0]       PAYLOAD,
  input  logic [3:0]                    SYNC_SEL,
  output logic                          MOD_EN,
  output logic                          BUSY,
  output logic [$clog2(PAYLOAD_BITS):0] BIT_IDX,
  output logic                          DONE,
  output logic                          RUNT
);

  localparam int IDX_W = $clog2(PAYLOAD_BITS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_PKT);

  sched_state_t            state_q;
  logic [PAYLOAD_BITS-1:0] pay_q;
  logic [DLY_W-1:0]        dly_q;
  logic [DLY_W-1:0]        dly_cnt;
  logic [DLY_W-1:0]        dly_now;
  logic                    rise;
  logic                    fall;
  logic [LEN_W-1:0]        pkt_len;

  pkt_edge_timer u_edge (
    .CLK     (CLK),
    .RST     (RST),
    .DEC_IN  (DEC_IN),
    .rise    (rise),
    .fall    (fall),
    .pkt_len (pkt_len)
  );

  // Only consumed on the rise cycle, so later SYNC_SEL changes cannot move this packet
  assign dly_now = sync_delay(SYNC_SEL, SYNC_BASE, SYNC_STEP);

  // Frame FSM, payload shifter and all registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pay_q   <= '0;
      dly_q   <= '0;
      dly_cnt <= '0;
      MOD_EN  <= 1'b0;
      BUSY    <= 1'b0;
      BIT_IDX <= '0;
      DONE    <= 1'b0;
      RUNT    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      RUNT <= 1'b0;
      if (LOAD) begin
        // A new frame always wins, even over a rise in the same cycle
        state_q <= ST_ARMED;
        pay_q   <= PAYLOAD;
        BIT_IDX <= '0;
        MOD_EN  <= 1'b0;
        BUSY    <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            MOD_EN <= 1'b0;
            BUSY   <= 1'b0;
          end

          ST_ARMED: begin
            // Only a fresh edge starts a bit; a level already high is ignored
            if (rise) begin
              dly_q <= dly_now;
              // The rise cycle itself is tick 0 of the delay
              dly_cnt <= DLY_W'(1);
              if (dly_now == '0) begin
                state_q <= ST_ACTIVE;
                MOD_EN  <= pay_q[0];
              end else begin
                state_q <= ST_DELAY;
              end
            end
          end

          ST_DELAY: begin
            if (fall) begin
              // Packet vanished before the window could open: retry this bit
              RUNT    <= 1'b1;
              state_q <= ST_ARMED;
            end else if (dly_cnt == dly_q) begin
              state_q <= ST_ACTIVE;
              MOD_EN  <= pay_q[0];
            end else begin
              dly_cnt <= dly_cnt + DLY_W'(1);
            end
          end

          ST_ACTIVE: begin
            if (fall) begin
              MOD_EN <= 1'b0;
              if (pkt_len >= MIN_LEN) begin
                pay_q   <= pay_q >> 1;
                BIT_IDX <= BIT_IDX + IDX_W'(1);
                if (BIT_IDX == LAST_IDX) begin
                  DONE    <= 1'b1;
                  BUSY    <= 1'b0;
                  state_q <= ST_IDLE;
                end else begin
                  state_q <= ST_ARMED;
                end
              end else begin
                RUNT    <= 1'b1;
                state_q <= ST_ARMED;
              end
            end
          end

          default: begin
            state_q <= ST_IDLE;
            MOD_EN  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_backscatter_scheduler.sv
// Directed bench for backscatter_scheduler: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_backscatter_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DEC_IN;
  logic        LOAD;
  logic [15:0] PAYLOAD;
  logic [3:0]  SYNC_SEL;
  logic        MOD_EN;
  logic        BUSY;
  logic [4:0]  BIT_IDX;
  logic        DONE;
  logic        RUNT;

  int n_checks = 0;
  int n_fail   = 0;

  backscatter_scheduler dut (
    .CLK      (CLK),
    .RST      (RST),
    .DEC_IN   (DEC_IN),
    .LOAD     (LOAD),
    .PAYLOAD  (PAYLOAD),
    .SYNC_SEL (SYNC_SEL),
    .MOD_EN   (MOD_EN),
    .BUSY     (BUSY),
    .BIT_IDX  (BIT_IDX),
    .DONE     (DONE),
    .RUNT     (RUNT)
  );

  always #25 CLK = ~CLK;

  typedef struct {
    bit          do_load;
    logic [15:0] payload;
    logic [3:0]  sel;
    int          len;
    int          exp_first;  // cycles after rise cycle MOD_EN first seen high, -1 = never
    int          exp_idx;
    int          exp_runt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] p, input string tag);
    @(negedge CLK);
    LOAD    = 1'b1;
    PAYLOAD = p;
    @(negedge CLK);
    check({tag, " busy after load"}, 32'(BUSY), 32'd1);
    check({tag, " idx after load"}, 32'(BIT_IDX), 32'd0);
    LOAD = 1'b0;
  endtask

  // Drive one packet of len high cycles; sample cycles 1..len+4 after the rise cycle
  task automatic send_pkt(input int len, output int first_on, output int on_cnt,
                          output int runts, output int dones,
                          output int busy_pre, output int busy_post);
    first_on  = -1;
    on_cnt    = 0;
    runts     = 0;
    dones     = 0;
    busy_pre  = -1;
    busy_post = -1;
    @(negedge CLK);
    DEC_IN = 1'b1;
    for (int k = 1; k <= len + 4; k++) begin
      @(negedge CLK);
      if (MOD_EN === 1'b1) begin
        on_cnt++;
        if (first_on < 0) first_on = k;
      end
      if (RUNT === 1'b1) runts++;
      if (DONE === 1'b1) dones++;
      if (k == len) busy_pre = int'(BUSY);
      if (k == len + 1) busy_post = int'(BUSY);
      // the step code must no longer matter once the packet has started
      if (k == 2) SYNC_SEL = 4'd0;
      if (k == len) DEC_IN = 1'b0;
    end
  endtask

  vec_t        vecs [13];
  logic [15:0] frame;
  int          f, o, r, d, bp, bq, exp_on;

  initial begin
    vecs[0]  = '{1'b1, 16'h0001, 4'd4,  900, 13, 1, 0};
    vecs[1]  = '{1'b1, 16'h0000, 4'd4,  900, -1, 1, 0};
    vecs[2]  = '{1'b1, 16'hFFFF, 4'd0,  900,  1, 1, 0};
    vecs[3]  = '{1'b1, 16'hFFFF, 4'd8,  900, 25, 1, 0};
    vecs[4]  = '{1'b1, 16'hFFFF, 4'd12, 900, 25, 1, 0};
    vecs[5]  = '{1'b1, 16'h0001, 4'd3,  900, 10, 1, 0};
    vecs[6]  = '{1'b1, 16'hFFFF, 4'd4,  500, 13, 0, 1};
    vecs[7]  = '{1'b0, 16'h0000, 4'd4,  900, 13, 1, 0};
    vecs[8]  = '{1'b0, 16'h0000, 4'd15, 900, 25, 2, 0};
    vecs[9]  = '{1'b1, 16'h0003, 4'd4,   10, -1, 0, 1};
    vecs[10] = '{1'b0, 16'h0000, 4'd0,  900,  1, 1, 0};
    vecs[11] = '{1'b0, 16'h0000, 4'd0,  820,  1, 2, 0};
    vecs[12] = '{1'b0, 16'h0000, 4'd0,  819, -1, 2, 1};

    RST      = 1'b1;
    DEC_IN   = 1'b0;
    LOAD     = 1'b0;
    PAYLOAD  = '0;
    SYNC_SEL = 4'd4;
    repeat (3) @(negedge CLK);
    check("reset mod_en", 32'(MOD_EN), 32'd0);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset bit_idx", 32'(BIT_IDX), 32'd0);
    check("reset done", 32'(DONE), 32'd0);
    check("reset runt", 32'(RUNT), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_load) do_load(vecs[i].payload, $sformatf("vec%0d", i));
      SYNC_SEL = vecs[i].sel;
      send_pkt(vecs[i].len, f, o, r, d, bp, bq);
      exp_on = (vecs[i].exp_first < 0) ? 0 : vecs[i].len - vecs[i].exp_first + 1;
      check($sformatf("vec%0d first_on", i), 32'(f), 32'(vecs[i].exp_first));
      check($sformatf("vec%0d on_cycles", i), 32'(o), 32'(exp_on));
      check($sformatf("vec%0d bit_idx", i), 32'(BIT_IDX), 32'(vecs[i].exp_idx));
      check($sformatf("vec%0d runt", i), 32'(r), 32'(vecs[i].exp_runt));
      check($sformatf("vec%0d done", i), 32'(d), 32'd0);
    end

    // Full 16-bit frame, LSB first, DONE on the last fall only
    frame = 16'hA5C3;
    do_load(frame, "frame");
    for (int i = 0; i < 16; i++) begin
      SYNC_SEL = 4'd0;
      send_pkt(900, f, o, r, d, bp, bq);
      check($sformatf("frame bit%0d mod_en", i), 32'(o > 0), 32'(frame[i]));
      check($sformatf("frame bit%0d done", i), 32'(d), (i == 15) ? 32'd1 : 32'd0);
      if (i == 15) begin
        check("frame busy before last fall", 32'(bp), 32'd1);
        check("frame busy at done edge", 32'(bq), 32'd0);
      end
    end
    check("frame final idx", 32'(BIT_IDX), 32'd16);

    // LOAD during ACTIVE: enable drops, index restarts, held envelope ignored
    do_load(16'hFFFF, "midload");
    SYNC_SEL = 4'd0;
    @(negedge CLK);
    DEC_IN = 1'b1;
    repeat (50) @(negedge CLK);
    check("midload mod_en before", 32'(MOD_EN), 32'd1);
    LOAD    = 1'b1;
    PAYLOAD = 16'h0001;
    @(negedge CLK);
    check("midload mod_en next edge", 32'(MOD_EN), 32'd0);
    check("midload bit_idx", 32'(BIT_IDX), 32'd0);
    check("midload busy", 32'(BUSY), 32'd1);
    LOAD = 1'b0;
    o = 0; d = 0; r = 0;
    repeat (900) begin
      @(negedge CLK);
      o += int'(MOD_EN);
      d += int'(DONE);
      r += int'(RUNT);
    end
    DEC_IN = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      d += int'(DONE);
      r += int'(RUNT);
    end
    check("midload held high mod_en", 32'(o), 32'd0);
    check("midload no done", 32'(d), 32'd0);
    check("midload no runt", 32'(r), 32'd0);
    check("midload idx held", 32'(BIT_IDX), 32'd0);
    send_pkt(900, f, o, r, d, bp, bq);
    check("midload fresh first_on", 32'(f), 32'd1);
    check("midload fresh idx", 32'(BIT_IDX), 32'd1);

    // LOAD and rise in the same cycle: that rise is consumed by LOAD
    @(negedge CLK);
    LOAD    = 1'b1;
    PAYLOAD = 16'h0001;
    DEC_IN  = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    o = 0; r = 0;
    repeat (900) begin
      @(negedge CLK);
      o += int'(MOD_EN);
      r += int'(RUNT);
    end
    DEC_IN = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      r += int'(RUNT);
    end
    check("loadrise mod_en", 32'(o), 32'd0);
    check("loadrise runt", 32'(r), 32'd0);
    check("loadrise idx", 32'(BIT_IDX), 32'd0);

    // Reset in the middle of an active packet
    do_load(16'hFFFF, "rstmid");
    SYNC_SEL = 4'd0;
    @(negedge CLK);
    DEC_IN = 1'b1;
    repeat (20) @(negedge CLK);
    check("rstmid mod_en before", 32'(MOD_EN), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("rstmid mod_en", 32'(MOD_EN), 32'd0);
    check("rstmid busy", 32'(BUSY), 32'd0);
    check("rstmid idx", 32'(BIT_IDX), 32'd0);
    RST    = 1'b0;
    DEC_IN = 1'b0;
    repeat (3) @(negedge CLK);
    send_pkt(900, f, o, r, d, bp, bq);
    check("rstmid idle ignores packet", 32'(o), 32'd0);
    check("rstmid idle idx", 32'(BIT_IDX), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
